dsi_lanes_distributor: RTL

//  Downstream neighbour of the DSI packets assembler. Accepts the assembled 32-bit byte stream
//  (word + contiguous byte strobe + last-word flag) and splits it byte-wise across 1..4 HS data lanes.

---
 rtl/dsi_lanes_distributor_pkg.sv | 33 +++
 rtl/dsi_lanes_distributor_if.sv | 27 ++
 rtl/dsi_lanes_distributor_byte_buffer.sv | 61 ++++++
 rtl/dsi_lanes_distributor.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dsi_lanes_distributor_pkg.sv
// Shared types and helpers for the DSI lane distributor.
// Holds the burst FSM states and the strobe decoding helpers.
package dsi_pkg;

  localparam int LANES_MAX = 4;
  localparam int BUF_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAKE,
    SEND,
    TRAIL
  } dist_state_t;

  function automatic logic [2:0] strb_to_nbytes(
    input logic [3:0] s
  );
    if (s[3]) return 3'd4;
    else if (s[2]) return 3'd3;
    else if (s[1]) return 3'd2;
    else if (s[0]) return 3'd1;
    else return 3'd0;
  endfunction

  function automatic logic strb_ok(
    input logic [3:0] s
  );
    return s inside {4'b0000, 4'b0001,
                     4'b0011, 4'b0111,
                     4'b1111};
  endfunction

endpackage

// File: rtl/dsi_lanes_distributor_if.sv
// Word stream from the packets assembler into the distributor.
// master = assembler side, slave = distributor side.
interface dsi_lanes_distributor_if;

  logic [31:0] in_write_data;
  logic [3:0]  in_write_strb;
  logic        in_write_rqst;
  logic        in_last_word;
  logic        in_data_rqst;

  modport master (
    output in_write_data,
    output in_write_strb,
    output in_write_rqst,
    output in_last_word,
    input  in_data_rqst
  );

  modport slave (
    input  in_write_data,
    input  in_write_strb,
    input  in_write_rqst,
    input  in_last_word,
    output in_data_rqst
  );

endinterface

// File: rtl/dsi_lanes_distributor_byte_buffer.sv
// Byte staging FIFO: append up to 4 bytes at the tail and
// drop up to LANES_MAX bytes from the head in the same cycle.
module dsi_byte_buffer #(
  parameter int BUF_BYTES = 8,
  parameter int LANES_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   push_data,
  input  logic [2:0]                    push_n,
  input  logic [2:0]                    pop_n,
  output logic [8*LANES_MAX-1:0]        head,
  output logic [$clog2(BUF_BYTES+1)-1:0] cnt
);

  localparam int CW = $clog2(BUF_BYTES+1);

  logic [7:0]    mem   [BUF_BYTES];
  logic [7:0]    mem_d [BUF_BYTES];
  logic [CW-1:0] cnt_d;

  // Shift out popped bytes, then land pushed bytes right after survivors.
  always_comb begin
    int c;
    int p;
    int n;
    int base;
    c = int'(cnt);
    p = int'(pop_n);
    n = int'(push_n);
    base = c - p;
    for (int i = 0; i < BUF_BYTES; i++) begin
      mem_d[i] = 8'h00;
      if (i + p < c) begin
        mem_d[i] = mem[i+p];
      end else if (i >= base && i < base + n) begin
        mem_d[i] = push_data[8*(i-base) +: 8];
      end
    end
    cnt_d = CW'(c + n - p);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < BUF_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      cnt <= cnt_d;
      for (int i = 0; i < BUF_BYTES; i++) begin
        mem[i] <= mem_d[i];
      end
    end
  end

  for (genvar k = 0; k < LANES_MAX; k++) begin : g_head
    assign head[8*k +: 8] = mem[k];
  end

endmodule

// File: rtl/dsi_lanes_distributor.sv
// Splits the assembled DSI byte stream over 1..LANES_MAX HS lanes
// and sequences each HS burst (request, beats, EoT, back to LP-11).
module dsi_lanes_distributor #(
  parameter int LANES_MAX = dsi_pkg::LANES_MAX,
  parameter int BUF_BYTES = dsi_pkg::BUF_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               lanes_number,
  dsi_lanes_distributor_if.slave   bus,
  output logic [LANES_MAX-1:0]     lane_hs_rqst,
  output logic [8*LANES_MAX-1:0]   lane_data,
  output logic [LANES_MAX-1:0]     lane_valid,
  input  logic                     phy_hs_ready,
  input  logic                     phy_stop_state,
  output logic                     err_strb
);

  import dsi_pkg::*;

  localparam int CW = $clog2(BUF_BYTES+1);

  dist_state_t state;
  dist_state_t state_d;

  logic [1:0]           lanes_q;
  logic [1:0]           lanes_lim;
  logic                 last_q;
  logic                 err_q;
  logic                 hs_on;
  logic [CW-1:0]        cnt;
  logic [8*LANES_MAX-1:0] head;
  logic [2:0]           n_lanes;
  logic [2:0]           n_pop;
  logic [2:0]           push_n;
  logic [2:0]           pop_n;
  logic                 accept;
  logic                 avail;
  logic [LANES_MAX-1:0] lane_mask;

  assign lanes_lim = (int'(lanes_number) > LANES_MAX-1)
                   ? 2'(LANES_MAX-1) : lanes_number;
  assign n_lanes = {1'b0, lanes_q} + 3'd1;
  assign n_pop   = (int'(cnt) < int'(n_lanes))
                 ? cnt[2:0] : n_lanes;

  assign bus.in_data_rqst = (state == WAKE || state == SEND)
                          && int'(cnt) <= BUF_BYTES-4
                          && !last_q;
  assign accept = bus.in_write_rqst & bus.in_data_rqst;
  assign push_n = accept ? strb_to_nbytes(bus.in_write_strb) : 3'd0;

  // A short final beat is allowed only once the last word is in.
  assign avail = state == SEND
              && (int'(cnt) >= int'(n_lanes)
                  || (last_q && cnt != '0));
  assign pop_n = (avail && phy_hs_ready) ? n_pop : 3'd0;

  dsi_byte_buffer #(
    .BUF_BYTES (BUF_BYTES),
    .LANES_MAX (LANES_MAX)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_data (bus.in_write_data),
    .push_n    (push_n),
    .pop_n     (pop_n),
    .head      (head),
    .cnt       (cnt)
  );

  always_comb begin
    state_d = state;
    hs_on   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && bus.in_write_rqst) state_d = WAKE;
      end
      WAKE: begin
        hs_on = 1'b1;
        if (phy_hs_ready) state_d = SEND;
      end
      SEND: begin
        hs_on = 1'b1;
        if (last_q && cnt == CW'(pop_n)) state_d = TRAIL;
      end
      TRAIL: begin
        if (phy_stop_state) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lanes_q <= 2'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && state_d == WAKE) lanes_q <= lanes_lim;
      if (accept && bus.in_last_word) last_q <= 1'b1;
      else if (state == TRAIL && phy_stop_state) last_q <= 1'b0;
      if (accept && !strb_ok(bus.in_write_strb)) err_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < LANES_MAX; k++) begin : g_lane
    assign lane_mask[k]  = k < int'(n_lanes);
    assign lane_valid[k] = avail && (k < int'(n_pop));
    assign lane_data[8*k +: 8] = lane_valid[k]
                               ? head[8*k +: 8] : 8'h00;
  end

  assign lane_hs_rqst = hs_on ? lane_mask : '0;
  assign err_strb     = err_q;

endmodule
